vram_arbiter: RTL
=================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter BA_WAIT, default 1: 1 = grant the VPU only after cpu_ba is high; 0 = grant once cpu_vma is low.
REQ-002 Parameter REL_CYCLES, default 1: number of turnaround cycles after a VPU release before the CPU gets the bus, range 1-3.
REQ-003 clk  in  1  system clock; all logic samples on the rising edge.
REQ-004 rst  in  1  synchronous reset, active-low.
REQ-005 cpu_addr  in  16  CPU address.
REQ-006 cpu_di  in  8  CPU write data.
REQ-007 cpu_rw  in  1  1 = read, 0 = write.
REQ-008 cpu_vma  in  1  CPU valid memory access.
REQ-009 cpu_ba  in  1  CPU bus-available acknowledge.
REQ-010 cpu_do  out  8  read data returned to the CPU.
REQ-011 cpu_halt  out  1  CPU halt request.
REQ-012 vpu_hold  in  1  VPU DMA bus request.
REQ-013 vpu_vramcs  in  1  VPU DMA read strobe.
REQ-014 vpu_addr  in  16  VPU DMA address.
REQ-015 vpu_data  out  8  read data returned to the VPU.
REQ-016 vpu_grant  out  1  VPU owns the memory bus.
REQ-017 mem_addr  out  16  RAM address.
REQ-018 mem_do  out  8  RAM write data.
REQ-019 mem_di  in  8  RAM read data, valid one clk after mem_cs.
REQ-020 mem_cs  out  1  RAM select.
REQ-021 mem_we  out  1  RAM write enable.

Function
REQ-022 The FSM SHALL have four states: CPU, REQ, VPU and REL.
REQ-023 In state CPU: mem_addr = cpu_addr, mem_cs = cpu_vma, mem_we = cpu_vma & ~cpu_rw, mem_do = cpu_di, cpu_halt = 0, vpu_grant = 0.
REQ-024 CPU->REQ SHALL occur on the first rising edge with vpu_hold = 1; in REQ, cpu_halt = 1 and the CPU path stays connected so an in-flight access completes.
REQ-025 REQ->VPU SHALL occur when cpu_ba = 1 (BA_WAIT = 1) or cpu_vma = 0 (BA_WAIT = 0).
REQ-026 REQ->CPU SHALL occur if vpu_hold drops before the grant is given; cpu_halt clears on the same edge.
REQ-027 In state VPU: vpu_grant = 1, cpu_halt = 1, mem_addr = vpu_addr, mem_cs = vpu_vramcs, mem_we = 0 (the VPU never writes).
REQ-028 Worst-case latency from vpu_hold rising to vpu_grant rising SHALL be 2 clk when BA_WAIT = 0 and the CPU is idle.
REQ-029 vpu_data SHALL be a register loaded from mem_di one clk after a cycle with mem_cs = 1 in state VPU, and held otherwise.
REQ-030 cpu_do SHALL be a register loaded from mem_di one clk after a CPU read cycle (mem_cs = 1, cpu_rw = 1), and held otherwise.
REQ-031 VPU->REL SHALL occur when vpu_hold = 0; REL SHALL last REL_CYCLES clk with mem_cs = 0, cpu_halt = 1 and vpu_grant = 0, then go to CPU.
REQ-032 If vpu_hold reasserts during REL, the FSM SHALL finish REL, enter CPU for at least one clk, then re-enter REQ (the CPU gets a minimum service window).
REQ-033 If vpu_vramcs = 1 while the state is not VPU, the strobe SHALL be ignored: no RAM access and vpu_data unchanged.
REQ-034 mem_we SHALL never be 1 in REQ->VPU transition cycles, VPU or REL.

Reset
REQ-035 While rst = 0, on each clk edge: state = CPU, cpu_halt = 0, vpu_grant = 0, cpu_do = 0x00, vpu_data = 0x00, REL counter = 0.
REQ-036 Asserting reset mid-grant SHALL return bus ownership to the CPU path on the next edge; no partial state survives.

Configuration
REQ-037 Macro VRAM_ARB_STEAL_CNT_EN defined: add output steal_cnt[15:0], which increments by 1 each clk in state VPU, saturates at 0xFFFF, and clears to 0 on reset and on each CPU->REQ transition.
REQ-038 Macro VRAM_ARB_STEAL_CNT_EN undefined: the steal_cnt port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-039 Scenario 1: BA_WAIT=0, CPU idle, vpu_hold=1 at cycle 0 -> cpu_halt=1 at cycle 1, vpu_grant=1 at cycle 2.
REQ-040 Scenario 2: in VPU, vpu_addr=0x1234, vpu_vramcs=1, RAM[0x1234]=0xA5 -> mem_addr=0x1234, mem_we=0, vpu_data=0xA5 one clk later.
REQ-041 Scenario 3: BA_WAIT=1, CPU write 0x5A to 0x2000 in flight when vpu_hold rises -> write completes, grant waits for cpu_ba=1, RAM[0x2000]=0x5A.
REQ-042 Scenario 4: REL_CYCLES=2, vpu_hold drops, then reasserts 1 clk later -> 2 REL cycles, >=1 CPU cycle with cpu_halt=0, then REQ.
REQ-043 Scenario 5: rst=0 pulsed while vpu_grant=1 -> next edge vpu_grant=0, cpu_halt=0, outputs match REQ-035.
REQ-044 Scenario 6 (VRAM_ARB_STEAL_CNT_EN): 40-clk grant -> steal_cnt=40; next request clears it to 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// VRAM bus arbiter: the CPU owns the RAM by default; the VPU takes it over for DMA reads via halt/BA handshake.
// Optional macro VRAM_ARB_STEAL_CNT_EN adds steal_cnt, counting clocks the VPU held the bus.
module vram_arbiter #(
  parameter int BA_WAIT    = 1,
  parameter int REL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_di,
  input  logic        cpu_rw,
  input  logic        cpu_vma,
  input  logic        cpu_ba,
  output logic [7:0]  cpu_do,
  output logic        cpu_halt,
  input  logic        vpu_hold,
  input  logic        vpu_vramcs,
  input  logic [15:0] vpu_addr,
  output logic [7:0]  vpu_data,
  output logic        vpu_grant,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_do,
  input  logic [7:0]  mem_di,
  output logic        mem_cs,
  output logic        mem_we
`ifdef VRAM_ARB_STEAL_CNT_EN
  ,
  output logic [15:0] steal_cnt
`endif
);

  localparam logic [1:0] ST_CPU   = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_VPU   = 2'd2;
  localparam logic [1:0] ST_REL   = 2'd3;
  localparam logic [1:0] REL_LAST = 2'(REL_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [1:0] rel_cnt_q, rel_cnt_d;
  logic       cpu_rd_q, vpu_rd_q;
  logic [7:0] cpu_do_q, vpu_data_q;
  logic       bus_free, grant_now, cpu_path;

  // With BA_WAIT the CPU must acknowledge; otherwise any cycle without a CPU access will do.
  assign bus_free  = (BA_WAIT != 0) ? cpu_ba : ~cpu_vma;
  assign grant_now = (state_q == ST_REQ) & vpu_hold & bus_free;
  assign cpu_path  = (state_q == ST_CPU) | (state_q == ST_REQ);

  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    case (state_q)
      ST_CPU: begin
        if (vpu_hold) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!vpu_hold)     state_d = ST_CPU;
        else if (bus_free) state_d = ST_VPU;
      end
      ST_VPU: begin
        if (!vpu_hold) begin
          state_d   = ST_REL;
          rel_cnt_d = 2'd0;
        end
      end
      default: begin
        // REL always falls through to CPU, giving the CPU at least one cycle before the next request
        if (rel_cnt_q == REL_LAST) begin
          state_d   = ST_CPU;
          rel_cnt_d = 2'd0;
        end else begin
          rel_cnt_d = rel_cnt_q + 2'd1;
        end
      end
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_do    = cpu_di;
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    cpu_halt  = 1'b0;
    vpu_grant = 1'b0;
    case (state_q)
      ST_CPU: begin
        mem_cs = cpu_vma;
        mem_we = cpu_vma & ~cpu_rw;
      end
      ST_REQ: begin
        // The in-flight CPU access still completes, but never as a write on the handover edge.
        mem_cs   = cpu_vma;
        mem_we   = cpu_vma & ~cpu_rw & ~grant_now;
        cpu_halt = 1'b1;
      end
      ST_VPU: begin
        mem_addr  = vpu_addr;
        mem_cs    = vpu_vramcs;
        cpu_halt  = 1'b1;
        vpu_grant = 1'b1;
      end
      default: begin
        cpu_halt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_CPU;
      rel_cnt_q  <= 2'd0;
      cpu_rd_q   <= 1'b0;
      vpu_rd_q   <= 1'b0;
      cpu_do_q   <= 8'h00;
      vpu_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      rel_cnt_q <= rel_cnt_d;
      // RAM returns data one clock after the select, so capture a clock after the access
      cpu_rd_q  <= cpu_path & cpu_vma & cpu_rw;
      vpu_rd_q  <= (state_q == ST_VPU) & vpu_vramcs;
      if (cpu_rd_q) cpu_do_q <= mem_di;
      if (vpu_rd_q) vpu_data_q <= mem_di;
    end
  end

  assign cpu_do   = cpu_do_q;
  assign vpu_data = vpu_data_q;

`ifdef VRAM_ARB_STEAL_CNT_EN
  logic [15:0] steal_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      steal_q <= 16'h0000;
    end else if (state_q == ST_CPU && vpu_hold) begin
      steal_q <= 16'h0000;
    end else if (state_q == ST_VPU && steal_q != 16'hFFFF) begin
      steal_q <= steal_q + 16'd1;
    end
  end

  assign steal_cnt = steal_q;
`endif

endmodule
